// File: rtl/ddr3_arbiter.sv
// ddr3_arbiter: shares one Avalon-MM DDR3 master port between a display
// read-burst client and single-word test write/read requests.
// Display has strict priority over pending test ops. Defining
// DDR3_ARB_STARVE_GUARD_EN bounds how many display grants may pass a
// pending test op (DISP_MAX).
//
// state          | meaning
// ---------------+------------------------------------------------------
// S_IDLE         | select next client (display > test write > test read)
// S_DISP_CMD     | display burst read command held until accepted
// S_DISP_DATA    | forwarding display beats, counting down to the last
// S_TEST_WR      | single-word test write held until accepted
// S_TEST_RD_CMD  | single-word test read command held until accepted
// S_TEST_RD_DATA | waiting for the test read word
`timescale 1ns/1ps
module ddr3_arbiter #(
    parameter int DISP_MAX = 4
) (
    input  logic         ddr3_clk,
    input  logic         ddr3_reset_n,
    input  logic         disp_req,
    input  logic [25:0]  disp_addr,
    input  logic [7:0]   disp_len,
    output logic         disp_gnt,
    output logic         disp_rd_valid,
    output logic         disp_done,
    input  logic         test_wr_ddr3,
    input  logic         test_rd_ddr3,
    input  logic [25:0]  test_addr,
    input  logic [127:0] test_wr_data,
    output logic [127:0] test_rd_data,
    output logic         wr_finish,
    output logic         rd_finish,
    output logic [25:0]  avm_address,
    output logic         avm_read,
    output logic         avm_write,
    output logic [7:0]   avm_burstcount,
    output logic [127:0] avm_writedata,
    input  logic         avm_waitrequest,
    input  logic [127:0] avm_readdata,
    input  logic         avm_readdatavalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DISP_CMD,
        S_DISP_DATA,
        S_TEST_WR,
        S_TEST_RD_CMD,
        S_TEST_RD_DATA
    } state_t;

    localparam logic [7:0] L_DISP_MAX = 8'(DISP_MAX);

    state_t         r_state;
    logic           r_wr_pend;
    logic           r_rd_pend;
    logic [7:0]     r_beats_left;
    logic [7:0]     r_starve_cnt;
    logic           r_disp_gnt;
    logic           r_disp_done;
    logic           r_wr_finish;
    logic           r_rd_finish;
    logic [127:0]   r_test_rd_data;
    logic [25:0]    r_avm_address;
    logic           r_avm_read;
    logic           r_avm_write;
    logic [7:0]     r_avm_burstcount;
    logic [127:0]   r_avm_writedata;

    logic           w_idle;
    logic           w_test_pend;
    logic           w_force_test;
    logic           w_sel_disp;
    logic           w_sel_wr;
    logic           w_sel_rd;
    logic [7:0]     w_disp_len_eff;

    assign w_idle         = (r_state == S_IDLE);
    assign w_test_pend    = r_wr_pend | r_rd_pend;
    assign w_disp_len_eff = (disp_len == 8'd0) ? 8'd1 : disp_len;

`ifdef DDR3_ARB_STARVE_GUARD_EN
    assign w_force_test = w_test_pend && (r_starve_cnt >= L_DISP_MAX);
`else
    assign w_force_test = 1'b0;
`endif

    assign w_sel_disp = w_idle && disp_req && !w_force_test;
    assign w_sel_wr   = w_idle && !w_sel_disp && r_wr_pend;
    assign w_sel_rd   = w_idle && !w_sel_disp && !r_wr_pend && r_rd_pend;

    // Pending test requests: a pulse sets the flag, repeats merge, selection clears it.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
        end else begin
            r_wr_pend <= (r_wr_pend | test_wr_ddr3) & ~w_sel_wr;
            r_rd_pend <= (r_rd_pend | test_rd_ddr3) & ~w_sel_rd;
        end
    end

    // Count display grants made while a test op waits; any test grant restarts the count.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_starve_cnt <= 8'd0;
        end else if (w_sel_wr || w_sel_rd) begin
            r_starve_cnt <= 8'd0;
        end else if (w_sel_disp && w_test_pend && (r_starve_cnt < L_DISP_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 8'd1;
        end
    end

    // Main sequencer; every Avalon and handshake output is registered here.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            r_state          <= S_IDLE;
            r_beats_left     <= 8'd0;
            r_disp_gnt       <= 1'b0;
            r_disp_done      <= 1'b0;
            r_wr_finish      <= 1'b0;
            r_rd_finish      <= 1'b0;
            r_test_rd_data   <= '0;
            r_avm_address    <= '0;
            r_avm_read       <= 1'b0;
            r_avm_write      <= 1'b0;
            r_avm_burstcount <= 8'd0;
            r_avm_writedata  <= '0;
        end else begin
            r_disp_gnt  <= 1'b0;
            r_disp_done <= 1'b0;
            r_wr_finish <= 1'b0;
            r_rd_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_disp) begin
                        r_disp_gnt       <= 1'b1;
                        r_avm_read       <= 1'b1;
                        r_avm_address    <= disp_addr;
                        r_avm_burstcount <= w_disp_len_eff;
                        r_beats_left     <= w_disp_len_eff;
                        r_state          <= S_DISP_CMD;
                    end else if (w_sel_wr) begin
                        r_avm_write      <= 1'b1;
                        r_avm_address    <= test_addr;
                        r_avm_burstcount <= 8'd1;
                        r_avm_writedata  <= test_wr_data;
                        r_state          <= S_TEST_WR;
                    end else if (w_sel_rd) begin
                        r_avm_read       <= 1'b1;
                        r_avm_address    <= test_addr;
                        r_avm_burstcount <= 8'd1;
                        r_state          <= S_TEST_RD_CMD;
                    end
                end
                S_DISP_CMD: begin
                    if (!avm_waitrequest) begin
                        r_avm_read       <= 1'b0;
                        r_avm_address    <= '0;
                        r_avm_burstcount <= 8'd0;
                        r_state          <= S_DISP_DATA;
                    end
                end
                S_DISP_DATA: begin
                    if (avm_readdatavalid) begin
                        if (r_beats_left == 8'd1) begin
                            r_beats_left <= 8'd0;
                            r_disp_done  <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_beats_left <= r_beats_left - 8'd1;
                        end
                    end
                end
                S_TEST_WR: begin
                    if (!avm_waitrequest) begin
                        r_avm_write      <= 1'b0;
                        r_avm_address    <= '0;
                        r_avm_burstcount <= 8'd0;
                        r_avm_writedata  <= '0;
                        r_wr_finish      <= 1'b1;
                        r_state          <= S_IDLE;
                    end
                end
                S_TEST_RD_CMD: begin
                    if (!avm_waitrequest) begin
                        r_avm_read       <= 1'b0;
                        r_avm_address    <= '0;
                        r_avm_burstcount <= 8'd0;
                        r_state          <= S_TEST_RD_DATA;
                    end
                end
                S_TEST_RD_DATA: begin
                    if (avm_readdatavalid) begin
                        r_test_rd_data <= avm_readdata;
                        r_rd_finish    <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Display beats pass straight through; returns outside a display burst are dropped.
    assign disp_rd_valid  = (r_state == S_DISP_DATA) && avm_readdatavalid;

    assign disp_gnt       = r_disp_gnt;
    assign disp_done      = r_disp_done;
    assign wr_finish      = r_wr_finish;
    assign rd_finish      = r_rd_finish;
    assign test_rd_data   = r_test_rd_data;
    assign avm_address    = r_avm_address;
    assign avm_read       = r_avm_read;
    assign avm_write      = r_avm_write;
    assign avm_burstcount = r_avm_burstcount;
    assign avm_writedata  = r_avm_writedata;

endmodule

// File: tb/tb_ddr3_arbiter.sv
// Scoreboard bench for ddr3_arbiter: scenarios push the expected Avalon
// commands (in service order derived from the priority rules) and the
// expected completions; monitor processes compare what the DUT presents.
`timescale 1ns/1ps
module tb_ddr3_arbiter;
    localparam int DISP_MAX = 4;
    localparam int K_DISP = 0;
    localparam int K_WR   = 1;
    localparam int K_RD   = 2;

    typedef struct {
        int           kind;
        logic [25:0]  addr;
        logic [7:0]   bc;
        logic [127:0] data;
        int           gap;
    } op_t;

    logic         ddr3_clk = 1'b0;
    logic         ddr3_reset_n = 1'b1;
    logic         disp_req = 1'b0;
    logic [25:0]  disp_addr = '0;
    logic [7:0]   disp_len = '0;
    logic         disp_gnt, disp_rd_valid, disp_done;
    logic         test_wr_ddr3 = 1'b0;
    logic         test_rd_ddr3 = 1'b0;
    logic [25:0]  test_addr = '0;
    logic [127:0] test_wr_data = '0;
    logic [127:0] test_rd_data;
    logic         wr_finish, rd_finish;
    logic [25:0]  avm_address;
    logic         avm_read, avm_write;
    logic [7:0]   avm_burstcount;
    logic [127:0] avm_writedata;
    logic         avm_waitrequest = 1'b0;
    logic [127:0] avm_readdata = '0;
    logic         avm_readdatavalid = 1'b0;

    ddr3_arbiter #(.DISP_MAX(DISP_MAX)) dut (
        .ddr3_clk(ddr3_clk), .ddr3_reset_n(ddr3_reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
        .disp_gnt(disp_gnt), .disp_rd_valid(disp_rd_valid), .disp_done(disp_done),
        .test_wr_ddr3(test_wr_ddr3), .test_rd_ddr3(test_rd_ddr3),
        .test_addr(test_addr), .test_wr_data(test_wr_data), .test_rd_data(test_rd_data),
        .wr_finish(wr_finish), .rd_finish(rd_finish),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_burstcount(avm_burstcount), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid)
    );

    always #5 ddr3_clk = ~ddr3_clk;

    int  checks = 0;
    int  failures = 0;
    op_t exp_cmd[$];
    op_t exp_done[$];
    op_t sl_q[$];
    int  sl_beat = 0;
    bit  sl_real_disp = 1'b0;
    bit  rand_wait = 1'b0;
    bit  spurious_en = 1'b0;
    int  stall_left = 0;
    int  cnt_gnt = 0, cnt_disp_done = 0, cnt_wr_fin = 0, cnt_rd_fin = 0;
    int  mon_disp_beats = 0, last_disp_beats = 0;
    int  cmd_hold = 0, last_hold = 0;
    int  last_bc = 0, gnt_at_wr = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    function automatic op_t mk(input int k, input logic [25:0] a, input logic [7:0] bc,
                               input logic [127:0] d, input int gap);
        op_t o;
        o.kind = k; o.addr = a; o.bc = bc; o.data = d; o.gap = gap;
        return o;
    endfunction

    // Memory-side word returned for beat b of a burst starting at a.
    function automatic logic [127:0] beat_data(input logic [25:0] a, input int b);
        if (a == 26'h1234 && b == 0) return 128'h1234;
        return {32'hC0DE0000 + 32'(b), 70'd0, a};
    endfunction

    task automatic tick();
        @(posedge ddr3_clk);
        #1;
    endtask

    // Avalon slave: stalls, then returns beats for accepted reads, plus stray valids when idle.
    initial begin
        forever begin
            @(posedge ddr3_clk);
            #1;
            sl_real_disp = 1'b0;
            avm_readdatavalid = 1'b0;
            if (!ddr3_reset_n) begin
                sl_q.delete();
                sl_beat = 0;
                avm_waitrequest = 1'b0;
                continue;
            end
            if (stall_left > 0 && (avm_read || avm_write)) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else if (rand_wait) begin
                avm_waitrequest = ($urandom_range(0, 3) == 0);
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (sl_q.size() > 0) begin
                if (sl_q[0].gap > 0) begin
                    sl_q[0].gap--;
                end else begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = beat_data(sl_q[0].addr, sl_beat);
                    sl_real_disp = (sl_q[0].kind == K_DISP);
                    sl_beat++;
                    if (sl_beat == int'(sl_q[0].bc)) begin
                        void'(sl_q.pop_front());
                        sl_beat = 0;
                    end else if (rand_wait) begin
                        sl_q[0].gap = $urandom_range(0, 1);
                    end
                end
            end else if (spurious_en && $urandom_range(0, 5) == 0) begin
                avm_readdatavalid = 1'b1;
                avm_readdata = {$urandom, $urandom, $urandom, $urandom};
            end
        end
    end

    // Monitor: compares accepted commands, display beats and completion pulses.
    initial begin
        op_t e;
        forever begin
            @(negedge ddr3_clk);
            if (!ddr3_reset_n) begin
                cmd_hold = 0;
                continue;
            end
            if (avm_read || avm_write) begin
                check("rw_mutex", avm_read & avm_write, 1'b0);
                cmd_hold++;
            end
            if (disp_gnt) cnt_gnt++;
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                last_hold = cmd_hold;
                cmd_hold = 0;
                last_bc = int'(avm_burstcount);
                if (avm_write) gnt_at_wr = cnt_gnt;
                if (exp_cmd.size() == 0) begin
                    fail_evt("cmd_unexpected");
                end else begin
                    e = exp_cmd.pop_front();
                    check("cmd_is_write", avm_write, e.kind == K_WR);
                    check("cmd_addr", avm_address, e.addr);
                    check("cmd_burstcount", avm_burstcount, e.bc);
                    if (e.kind == K_WR) check("cmd_writedata", avm_writedata, e.data);
                    if (e.kind != K_WR) begin
                        if (e.gap < 0) e.gap = rand_wait ? $urandom_range(0, 2) : 0;
                        sl_q.push_back(e);
                    end
                    exp_done.push_back(e);
                end
            end
            if (disp_rd_valid || sl_real_disp) check("disp_rd_valid", disp_rd_valid, sl_real_disp);
            if (disp_rd_valid) mon_disp_beats++;
            if (disp_done) begin
                cnt_disp_done++;
                last_disp_beats = mon_disp_beats;
                if (exp_done.size() == 0) fail_evt("disp_done_unexpected");
                else begin
                    e = exp_done.pop_front();
                    check("done_kind_disp", e.kind, K_DISP);
                    check("disp_beat_count", mon_disp_beats, e.bc);
                end
                mon_disp_beats = 0;
            end
            if (wr_finish) begin
                cnt_wr_fin++;
                if (exp_done.size() == 0) fail_evt("wr_finish_unexpected");
                else begin
                    e = exp_done.pop_front();
                    check("done_kind_wr", e.kind, K_WR);
                end
            end
            if (rd_finish) begin
                cnt_rd_fin++;
                if (exp_done.size() == 0) fail_evt("rd_finish_unexpected");
                else begin
                    e = exp_done.pop_front();
                    check("done_kind_rd", e.kind, K_RD);
                    check("test_rd_data", test_rd_data, beat_data(e.addr, 0));
                end
            end
        end
    end

    task automatic wait_quiet(input int max_cyc);
        int cyc;
        cyc = 0;
        while ((exp_cmd.size() != 0 || exp_done.size() != 0) && cyc < max_cyc) begin
            tick();
            cyc++;
        end
        if (exp_cmd.size() != 0 || exp_done.size() != 0) begin
            failures++;
            checks++;
            $display("FAIL quiet_timeout actual=cmd%0d_done%0d required=empty", exp_cmd.size(), exp_done.size());
            exp_cmd.delete();
            exp_done.delete();
        end
        repeat (3) tick();
    endtask

    task automatic wait_gnt(input int g0);
        int cyc;
        cyc = 0;
        while (cnt_gnt == g0 && cyc < 100) begin
            tick();
            cyc++;
        end
        check("disp_gnt_seen", cnt_gnt != g0, 1'b1);
    endtask

    // Requests arrive together; service order is display, then write, then read.
    task automatic run_scenario(input bit do_disp, input int n_wr, input int n_rd,
                                input logic [25:0] da, input logic [7:0] dl,
                                input logic [25:0] ta, input logic [127:0] wd, input int rd_gap);
        int g0;
        g0 = cnt_gnt;
        test_addr = ta;
        test_wr_data = wd;
        if (do_disp) begin
            exp_cmd.push_back(mk(K_DISP, da, (dl == 8'd0) ? 8'd1 : dl, '0, -1));
            disp_addr = da;
            disp_len = dl;
            disp_req = 1'b1;
        end
        if (n_wr > 0) exp_cmd.push_back(mk(K_WR, ta, 8'd1, wd, -1));
        if (n_rd > 0) exp_cmd.push_back(mk(K_RD, ta, 8'd1, '0, rd_gap));
        test_wr_ddr3 = (n_wr > 0);
        test_rd_ddr3 = (n_rd > 0);
        tick();
        test_wr_ddr3 = do_disp && (n_wr > 1);
        test_rd_ddr3 = do_disp && (n_rd > 1);
        tick();
        test_wr_ddr3 = 1'b0;
        test_rd_ddr3 = 1'b0;
        if (do_disp) begin
            wait_gnt(g0);
            disp_req = 1'b0;
        end
        wait_quiet(2000);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int d0, w0, r0, g0, cyc, n_disp;
        #2;
        ddr3_reset_n = 1'b0;
        repeat (2) @(posedge ddr3_clk);
        @(negedge ddr3_clk);
        check("reset_ctrl_outputs",
              {disp_gnt, disp_rd_valid, disp_done, wr_finish, rd_finish, avm_read, avm_write, avm_burstcount, avm_address}, '0);
        check("reset_test_rd_data", test_rd_data, '0);
        check("reset_writedata", avm_writedata, '0);
        tick();
        ddr3_reset_n = 1'b1;
        repeat (2) tick();

        // Test write with three stall cycles, command latency from the pulse.
        w0 = cnt_wr_fin;
        stall_left = 3;
        test_addr = 26'h100;
        test_wr_data = {96'h0, 32'hDEADBEEF};
        exp_cmd.push_back(mk(K_WR, 26'h100, 8'd1, {96'h0, 32'hDEADBEEF}, -1));
        test_wr_ddr3 = 1'b1;
        @(negedge ddr3_clk);
        check("wr_latency_c0", avm_write, 1'b0);
        tick();
        test_wr_ddr3 = 1'b0;
        @(negedge ddr3_clk);
        check("wr_latency_c1", avm_write, 1'b0);
        @(negedge ddr3_clk);
        check("wr_latency_c2", avm_write, 1'b1);
        wait_quiet(200);
        check("wr_hold_cycles", last_hold, 4);
        check("wr_finish_pulses", cnt_wr_fin - w0, 1);

        // Test read returning 0x1234 two cycles after acceptance.
        r0 = cnt_rd_fin;
        run_scenario(1'b0, 0, 1, '0, 8'd0, 26'h1234, '0, 1);
        check("rd_data_1234", test_rd_data, 128'h1234);
        check("rd_finish_pulses", cnt_rd_fin - r0, 1);

        // Display bursts: length 16 and length 0.
        d0 = cnt_disp_done;
        run_scenario(1'b1, 0, 0, 26'h2000, 8'd16, '0, '0, -1);
        check("disp16_burstcount", last_bc, 16);
        check("disp16_beats", last_disp_beats, 16);
        check("disp16_done_pulses", cnt_disp_done - d0, 1);
        run_scenario(1'b1, 0, 0, 26'h3000, 8'd0, '0, '0, -1);
        check("disp_len0_burstcount", last_bc, 1);

        // Display, write and read together: order fixed by the scenario queue.
        run_scenario(1'b1, 1, 1, 26'h0400, 8'd4, 26'h0777, {4{32'h55AA00FF}}, -1);

        // Randomized mixes with stalls, gaps, repeats and stray readdatavalid.
        rand_wait = 1'b1;
        spurious_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            run_scenario(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
                         26'($urandom), ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12)),
                         26'($urandom), {$urandom, $urandom, $urandom, $urandom}, -1);
        end

        // Continuous display traffic with a test write pending.
        g0 = cnt_gnt;
        test_addr = 26'h0BEEF;
        test_wr_data = {4{32'h600DF00D}};
        test_wr_ddr3 = 1'b1;
        tick();
        test_wr_ddr3 = 1'b0;
        disp_addr = 26'h5000;
        disp_len = 8'd2;
        disp_req = 1'b1;
`ifdef DDR3_ARB_STARVE_GUARD_EN
        n_disp = DISP_MAX;
        for (int i = 0; i < DISP_MAX; i++) exp_cmd.push_back(mk(K_DISP, 26'h5000, 8'd2, '0, -1));
        exp_cmd.push_back(mk(K_WR, 26'h0BEEF, 8'd1, {4{32'h600DF00D}}, -1));
        for (int i = 0; i < 6 - DISP_MAX; i++) exp_cmd.push_back(mk(K_DISP, 26'h5000, 8'd2, '0, -1));
`else
        n_disp = 6;
        for (int i = 0; i < 6; i++) exp_cmd.push_back(mk(K_DISP, 26'h5000, 8'd2, '0, -1));
        exp_cmd.push_back(mk(K_WR, 26'h0BEEF, 8'd1, {4{32'h600DF00D}}, -1));
`endif
        cyc = 0;
        while (cnt_gnt - g0 < 6 && cyc < 1000) begin
            tick();
            cyc++;
        end
        disp_req = 1'b0;
        check("starve_grants", cnt_gnt - g0, 6);
        wait_quiet(2000);
        check("starve_disp_before_wr", gnt_at_wr - g0, n_disp);

        // Reset in the middle of a display data phase.
        rand_wait = 1'b0;
        spurious_en = 1'b0;
        g0 = cnt_gnt;
        exp_cmd.push_back(mk(K_DISP, 26'h0ABC00, 8'd16, '0, -1));
        disp_addr = 26'h0ABC00;
        disp_len = 8'd16;
        disp_req = 1'b1;
        wait_gnt(g0);
        disp_req = 1'b0;
        cyc = 0;
        while (mon_disp_beats < 3 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("rst_mid_burst_reached", mon_disp_beats >= 3, 1'b1);
        d0 = cnt_disp_done;
        ddr3_reset_n = 1'b0;
        #1;
        check("rst_ctrl_outputs",
              {disp_gnt, disp_rd_valid, disp_done, wr_finish, rd_finish, avm_read, avm_write, avm_burstcount, avm_address}, '0);
        check("rst_test_rd_data", test_rd_data, '0);
        check("rst_writedata", avm_writedata, '0);
        exp_cmd.delete();
        exp_done.delete();
        mon_disp_beats = 0;
        repeat (3) tick();
        ddr3_reset_n = 1'b1;
        repeat (6) tick();
        check("rst_no_disp_done", cnt_disp_done - d0, 0);
        d0 = cnt_disp_done;
        w0 = cnt_wr_fin;
        run_scenario(1'b1, 1, 0, 26'h0777, 8'd3, 26'h0321, {4{32'h0BADCAFE}}, -1);
        check("restart_disp_done", cnt_disp_done - d0, 1);
        check("restart_wr_finish", cnt_wr_fin - w0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ddr3_arbiter.md
DDR3_ARBITER -- requirements
Module: ddr3_arbiter

Interface
REQ-001 SHALL have parameter DISP_MAX, default 4: max consecutive display grants while a test op is pending (guard build only).
REQ-002 SHALL have port ddr3_clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port ddr3_reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port disp_req  input  1  display read-burst request; level, held until disp_gnt.
REQ-005 SHALL have port disp_addr  input  26  display burst start address, word units.
REQ-006 SHALL have port disp_len  input  8  display burst length in 128-bit beats.
REQ-007 SHALL have port disp_gnt  output  1  one-cycle pulse; display request accepted, addr/len latched.
REQ-008 SHALL have port disp_rd_valid  output  1  display beat valid; data is avm_readdata.
REQ-009 SHALL have port disp_done  output  1  one-cycle pulse after last display beat.
REQ-010 SHALL have port test_wr_ddr3  input  1  one-cycle test-write request pulse.
REQ-011 SHALL have port test_rd_ddr3  input  1  one-cycle test-read request pulse.
REQ-012 SHALL have port test_addr  input  26  test address; sampled at test-op start.
REQ-013 SHALL have port test_wr_data  input  128  test write data; sampled at test-write start.
REQ-014 SHALL have port test_rd_data  output  128  last captured test-read word.
REQ-015 SHALL have port wr_finish  output  1  one-cycle pulse; test write accepted by DDR3.
REQ-016 SHALL have port rd_finish  output  1  one-cycle pulse; test_rd_data updated.
REQ-017 SHALL have port avm_address  output  26  Avalon-MM master address.
REQ-018 SHALL have port avm_read  output  1  Avalon read command.
REQ-019 SHALL have port avm_write  output  1  Avalon write command.
REQ-020 SHALL have port avm_burstcount  output  8  Avalon burst count.
REQ-021 SHALL have port avm_writedata  output  128  Avalon write data.
REQ-022 SHALL have port avm_waitrequest  input  1  slave stall; command held while high.
REQ-023 SHALL have ports avm_readdata  input  128 and avm_readdatavalid  input  1  read return beats.

Function
REQ-024 SHALL be an FSM: IDLE, DISP_CMD, DISP_DATA, TEST_WR, TEST_RD_CMD, TEST_RD_DATA.
REQ-025 SHALL latch test_wr_ddr3/test_rd_ddr3 into pending flags; a repeat pulse while pending merges (no queue); a flag clears on entry to its op state.
REQ-026 IDLE priority SHALL be display > test write > test read; simultaneous wr+rd pulses serve write first, then read.
REQ-027 On display selection SHALL pulse disp_gnt, latch disp_addr/disp_len (disp_len 0 substituted by 1), enter DISP_CMD.
REQ-028 In DISP_CMD SHALL assert avm_read, latched address and burstcount until a cycle with avm_waitrequest low, then enter DISP_DATA.
REQ-029 In DISP_DATA SHALL drive disp_rd_valid = avm_readdatavalid, count beats, and pulse disp_done in the cycle after the final beat while returning to IDLE.
REQ-030 TEST_WR SHALL hold avm_write, burstcount 1, sampled address/data until avm_waitrequest low, then pulse wr_finish next cycle and return to IDLE.
REQ-031 TEST_RD_CMD SHALL hold avm_read, burstcount 1 until accepted; TEST_RD_DATA SHALL capture avm_readdata on first avm_readdatavalid, pulse rd_finish next cycle, return to IDLE.
REQ-032 avm_read/avm_write SHALL never both be high; readdatavalid outside DISP_DATA/TEST_RD_DATA SHALL be ignored.
REQ-033 Selection SHALL take one IDLE cycle; command SHALL appear the cycle after selection (2-cycle request-to-command latency).

Reset
REQ-034 On ddr3_reset_n low, SHALL immediately enter IDLE, clear pending flags and beat/starve counters, and drive all outputs 0, including test_rd_data; reset mid-burst abandons the burst without any disp_done or finish pulse.

Configuration
REQ-035 With DDR3_ARB_STARVE_GUARD_EN defined, after DISP_MAX consecutive display grants with a test op pending, the next IDLE selection SHALL serve the test op (counter resets on any test grant); undefined, display priority SHALL be strict.

Verification
REQ-036 test_wr_ddr3 pulse, addr 0x100, data 0x..DEADBEEF, waitrequest high 3 cycles -> avm_write held 4 cycles, one wr_finish pulse.
REQ-037 test_rd_ddr3 pulse, readdatavalid with 0x1234 two cycles after accept -> test_rd_data = 0x1234, single rd_finish pulse.
REQ-038 disp_req addr 0x2000 len 16 -> burstcount 16, 16 disp_rd_valid beats, one disp_done; len 0 -> burstcount 1.
REQ-039 simultaneous wr+rd pulses with disp_req high -> order display, write, read.
REQ-040 guard build, DISP_MAX=4, disp_req permanently high, test write pending -> write served after the 4th display burst; non-guard build: never served.
REQ-041 reset asserted mid DISP_DATA -> all outputs 0 same cycle, no disp_done, clean IDLE restart.
